mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
// - Synthesizable off-chip memory model; responder end of the proc2mem/mem2proc protocol.
// - Accepts one command per cycle from the accelerator's memory controller (K/V/Q loads, O stores).
// - Loads: grants a tag in the request cycle, returns 64-bit MEM_BLOCK data plus that tag LATENCY_CYCLES later.
// - Stores: commit to the backing array. Sits between the controller and the testbench/top-level memory slot.
// PARAMETERS
// - NUM_TAGS          15           max loads in flight; tags 1..NUM_TAGS; must fit MEM_TAG; 0 = "no tag"
// - LATENCY_CYCLES    4            cycles from load accept to data response; legal range >= 1
// - MEM_DEPTH_BLOCKS  4096         backing array depth, in 8-byte blocks
// - BASE_ADDR         'h0000_0000  byte address mapped to array index 0
// PORTS
// - clk                       in   1        clock
// - rst                       in   1        synchronous, active-high reset
// - proc2mem_command          in   MEM_COMMAND  MEM_NONE / MEM_LOAD / MEM_STORE
// - proc2mem_addr             in   ADDR     byte address; bits [2:0] ignored (block aligned)
// - proc2mem_data             in   MEM_BLOCK  store data
// - mem2proc_transaction_tag  out  MEM_TAG  combinational, same cycle as request; nonzero = load accepted
// - mem2proc_data             out  MEM_BLOCK  registered load data
// - mem2proc_data_tag         out  MEM_TAG  registered; nonzero for exactly one cycle per returned load
// - outstanding               out  $clog2(NUM_TAGS+1)  registered count of loads in flight
// - mem_err                   out  1        sticky flag: out-of-range access seen since reset
// BEHAVIOUR
// - Reset: clears all in-flight entries, tag free-list (all free), outstanding=0, mem2proc_data='0,
//   mem2proc_data_tag='0, mem_err=0. Reset mid-operation drops pending loads; no response is ever issued.
//   Backing array is NOT reset and keeps its contents. While rst=1, transaction_tag=0 and nothing commits.
// - Index = (proc2mem_addr - BASE_ADDR) >> 3. In range iff BASE_ADDR <= addr
//   and index < MEM_DEPTH_BLOCKS.
// - MEM_NONE: transaction_tag=0; no state change.
// - MEM_LOAD, free tag exists: transaction_tag = lowest-numbered free tag.
//   At the edge, that tag is marked busy and the array word is captured into the in-flight entry
//   (snapshot at accept), with countdown=LATENCY_CYCLES.
// - MEM_LOAD, no free tag: transaction_tag=0, request rejected and ignored.
//   Controller must reissue; no side effects.
// - MEM_STORE: always accepted; transaction_tag=0; array[index] <= proc2mem_data at the edge.
//   Load issued in the next cycle returns the new value. Load accepted earlier returns the old value.
// - Load response timing:
//   - Load presented in cycle k.
//   - mem2proc_data/data_tag are valid during cycle k+LATENCY_CYCLES.
//   - Exactly one cycle, then data_tag returns to 0 (data may hold).
// - Ordering: at most one accept per cycle and fixed latency, so at most one response per cycle.
//   Responses return in issue order.
// - Tag release: a tag is freed at the edge ending its response cycle.
//   It can be reallocated from the following cycle, never in its own response cycle.
// - outstanding: +1 on accept, -1 on response, unchanged when both happen on the same edge.
//   Never exceeds NUM_TAGS.
// - Out-of-range load: accepted normally (tag granted), returns data='0. Out-of-range store: dropped.
//   Both set mem_err=1 at that edge; mem_err clears only on rst.
// - A tag value is never live twice. data_tag is never nonzero for a tag that is not busy.
// CONFIGURATION
// - MEM_STALL_INJECT_EN defined:
//   - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 'hACE1) advances every non-reset cycle.
//   - When LFSR[1:0]==2'b00, an otherwise-acceptable MEM_LOAD is rejected: transaction_tag=0, no state change.
//   - Stores are never affected.
//   - Purpose: exercises controller retry paths.
// - MEM_STALL_INJECT_EN undefined: no LFSR is instantiated; loads are rejected only when all tags are busy.
// TESTING
// - Store 'hDEAD_BEEF_0123_4567 @BASE+'h40, then load @BASE+'h40 next cycle.
//   Required: tag=1 returned the same cycle; data_tag=1 with that data exactly 4 cycles later.
// - 16 back-to-back loads with NUM_TAGS=15, LATENCY_CYCLES=20.
//   Required: tags 1..15 granted in order, 16th gets tag 0.
//   outstanding=15 until the first response; tag 1 is regranted only the cycle after its response.
// - Load @A (array holds 'h11) in cycle 0, store 'h22 @A in cycle 1.
//   Required: response in cycle 4 carries 'h11; a new load of A returns 'h22.
// - Load @BASE+MEM_DEPTH_BLOCKS*8.
//   Required: tag granted, data='0, mem_err=1 and stays 1. Out-of-range store leaves array unchanged.
// - Issue 3 loads, assert rst for one cycle before any response.
//   Required: no nonzero data_tag ever appears; outstanding=0. A following load gets tag 1.
// - With MEM_STALL_INJECT_EN, stream 64 loads with retry-until-accepted.
//   Required: the rejection pattern matches the golden LFSR model from seed 'hACE1;
//   all 64 responses arrive in order with correct data.

Source files
------------

// File: rtl/mem_responder.sv
// Off-chip memory model answering the proc2mem/mem2proc protocol with fixed-latency tagged loads.
// Optional build macro MEM_STALL_INJECT_EN adds LFSR-driven random load rejection.
`timescale 1ns/1ps
module mem_responder #(
    parameter int                NUM_TAGS         = 15,
    parameter int                LATENCY_CYCLES   = 4,
    parameter int                MEM_DEPTH_BLOCKS = 4096,
    parameter int                TAG_W            = 4,
    parameter int                ADDR_W           = 32,
    parameter int                DATA_W           = 64,
    parameter logic [ADDR_W-1:0] BASE_ADDR        = 32'h0000_0000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [1:0]                        i_proc2mem_command,
    input  logic [ADDR_W-1:0]                 i_proc2mem_addr,
    input  logic [DATA_W-1:0]                 i_proc2mem_data,
    output logic [TAG_W-1:0]                  o_mem2proc_transaction_tag,
    output logic [DATA_W-1:0]                 o_mem2proc_data,
    output logic [TAG_W-1:0]                  o_mem2proc_data_tag,
    output logic [$clog2(NUM_TAGS+1)-1:0]     o_outstanding,
    output logic                              o_mem_err
);
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;
    localparam int IDX_W = $clog2(MEM_DEPTH_BLOCKS);
    localparam int CNT_W = $clog2(NUM_TAGS+1);

    logic [DATA_W-1:0] r_mem [MEM_DEPTH_BLOCKS];
    logic [NUM_TAGS:1] r_busy;
    logic [TAG_W-1:0]  r_data_tag;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_outstanding;
    logic              r_mem_err;

    logic [ADDR_W-1:0] w_offset;
    logic [IDX_W-1:0]  w_index;
    logic              w_in_range;
    logic [DATA_W-1:0] w_rd_data;
    logic [TAG_W-1:0]  w_free_tag;
    logic              w_stall;
    logic              w_accept;
    logic              w_store;
    logic              w_err;
    logic [TAG_W-1:0]  w_grant_tag;
    logic [NUM_TAGS:1] w_grant_mask;
    logic [NUM_TAGS:1] w_release_mask;
    logic [TAG_W-1:0]  w_resp_tag;
    logic [DATA_W-1:0] w_resp_data;

    // Address decode; the subtraction wraps for addresses below the base, so both bounds are checked.
    assign w_offset   = i_proc2mem_addr - BASE_ADDR;
    assign w_index    = w_offset[IDX_W+2:3];
    assign w_in_range = (i_proc2mem_addr >= BASE_ADDR) &&
                        ((w_offset >> 3) < ADDR_W'(MEM_DEPTH_BLOCKS));
    assign w_rd_data  = w_in_range ? r_mem[w_index] : '0;

`ifdef MEM_STALL_INJECT_EN
    logic [15:0] r_lfsr;

    // Fibonacci LFSR (taps 16,14,13,11) that paces injected load rejections
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        end
    end
    assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
    assign w_stall = 1'b0;
`endif

    // Lowest-numbered free tag; scanning downward lets the smallest index win
    always_comb begin
        w_free_tag = '0;
        for (int t = NUM_TAGS; t >= 1; t--) begin
            if (!r_busy[t]) begin
                w_free_tag = TAG_W'(t);
            end else begin
                w_free_tag = w_free_tag;
            end
        end
    end

    // Request acceptance, commit and error qualification
    always_comb begin
        w_accept    = 1'b0;
        w_store     = 1'b0;
        w_err       = 1'b0;
        w_grant_tag = '0;
        if (!rst) begin
            case (i_proc2mem_command)
                MEM_LOAD: begin
                    w_accept    = (w_free_tag != '0) && !w_stall;
                    w_grant_tag = w_accept ? w_free_tag : '0;
                    w_err       = w_accept && !w_in_range;
                end
                MEM_STORE: begin
                    w_store = w_in_range;
                    w_err   = !w_in_range;
                end
                default: begin
                    w_accept = 1'b0;
                end
            endcase
        end else begin
            w_accept = 1'b0;
        end
    end
    assign o_mem2proc_transaction_tag = w_grant_tag;

    // Per-tag set/clear masks for the busy vector
    always_comb begin
        w_grant_mask   = '0;
        w_release_mask = '0;
        for (int t = 1; t <= NUM_TAGS; t++) begin
            w_grant_mask[t]   = (w_grant_tag == TAG_W'(t));
            w_release_mask[t] = (r_data_tag == TAG_W'(t));
        end
    end

    // Backing store write port; intentionally not reset so contents survive rst
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[w_index] <= i_proc2mem_data;
        end
    end

    generate
        if (LATENCY_CYCLES == 1) begin : g_lat1
            assign w_resp_tag  = w_grant_tag;
            assign w_resp_data = w_rd_data;
        end else begin : g_pipe
            logic [TAG_W-1:0]  r_pipe_tag  [LATENCY_CYCLES-1];
            logic [DATA_W-1:0] r_pipe_data [LATENCY_CYCLES-1];

            // Delay line carrying granted tags; rst flushes it so dropped loads never answer
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < LATENCY_CYCLES-1; i++) begin
                        r_pipe_tag[i] <= '0;
                    end
                end else begin
                    r_pipe_tag[0] <= w_grant_tag;
                    for (int i = 1; i < LATENCY_CYCLES-1; i++) begin
                        r_pipe_tag[i] <= r_pipe_tag[i-1];
                    end
                end
            end

            // Load data snapshotted at accept time travels alongside its tag
            always_ff @(posedge clk) begin
                r_pipe_data[0] <= w_rd_data;
                for (int i = 1; i < LATENCY_CYCLES-1; i++) begin
                    r_pipe_data[i] <= r_pipe_data[i-1];
                end
            end

            assign w_resp_tag  = r_pipe_tag[LATENCY_CYCLES-2];
            assign w_resp_data = r_pipe_data[LATENCY_CYCLES-2];
        end
    endgenerate

    // Response registers; data holds between responses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_tag <= '0;
            r_data     <= '0;
        end else begin
            r_data_tag <= w_resp_tag;
            if (w_resp_tag != '0) begin
                r_data <= w_resp_data;
            end
        end
    end

    // Tag bookkeeping: a tag is released at the edge that ends its response cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_release_mask) | w_grant_mask;
        end
    end

    // In-flight counter and sticky range error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outstanding <= '0;
            r_mem_err     <= 1'b0;
        end else begin
            case ({w_accept, r_data_tag != '0})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_err) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    assign o_mem2proc_data     = r_data;
    assign o_mem2proc_data_tag = r_data_tag;
    assign o_outstanding       = r_outstanding;
    assign o_mem_err           = r_mem_err;
endmodule
